async_fourbc: RTL and testbench

- Binary up-counter, WIDTH bits (default 4), built as a chain of toggle-flop stages.
- Count sequence matches a classic 4-bit ripple counter. All stages run on the single system clock, so the counter is fully synchronous.
- `t` is a global count enable.
- Leaf utility block; feeds any logic needing a free-running or gated 4-bit count.

---
 rtl/async_fourbc_pkg.sv | 17 +
 rtl/async_fourbc_tff.sv | 18 +
 rtl/async_fourbc.sv | 46 ++++
 tb/tb_async_fourbc.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/async_fourbc_pkg.sv
// Shared constants and helpers for the async_fourbc toggle-chain counter.
package async_fourbc_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  // True when the lowest n bits of vec are all ones (n = 0 yields true).
  function automatic logic all_ones(input logic [MAX_WIDTH-1:0] vec, input int n);
    logic r_ones;
    r_ones = 1'b1;
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if (k < n) r_ones = r_ones & vec[k];
    end
    return r_ones;
  endfunction

endpackage

// File: rtl/async_fourbc_tff.sv
// Single toggle flip-flop stage with synchronous active-high reset.
module tff_stage (
  input  logic clk,
  input  logic reset,
  input  logic tin,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= 1'b0;
    else       r_q <= r_q ^ tin;
  end

  assign q = r_q;

endmodule

// File: rtl/async_fourbc.sv
// Synchronous binary up-counter built from a chain of toggle stages.
// Define ASYNC_FOURBC_TC_EN to add the combinational terminal-count output tc.
module async_fourbc
  import async_fourbc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t,
  output logic [WIDTH-1:0] q
`ifdef ASYNC_FOURBC_TC_EN
  ,
  output logic             tc
`endif
);

  logic [WIDTH-1:0]     w_tin;
  logic [MAX_WIDTH-1:0] w_qExt;

  always_comb begin
    w_qExt           = '0;
    w_qExt[WIDTH-1:0] = q;
  end

  // Stage i toggles only when every lower stage is 1, giving ripple order without ripple delay.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign w_tin[i] = t;
    end else begin : g_upper
      assign w_tin[i] = t & all_ones(w_qExt, i);
    end

    tff_stage u_tff (
      .clk   (clk),
      .reset (reset),
      .tin   (w_tin[i]),
      .q     (q[i])
    );
  end

`ifdef ASYNC_FOURBC_TC_EN
  assign tc = t & all_ones(w_qExt, WIDTH) & ~reset;
`endif

endmodule

// File: tb/tb_async_fourbc.sv
// Table-driven self-checking bench for async_fourbc (works with or without ASYNC_FOURBC_TC_EN).
module tb_async_fourbc;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         t;
  logic [W-1:0] q;
`ifdef ASYNC_FOURBC_TC_EN
  logic         tc;
`endif

  async_fourbc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .t     (t),
    .q     (q)
`ifdef ASYNC_FOURBC_TC_EN
    ,
    .tc    (tc)
`endif
  );

  typedef struct {
    logic         reset;
    logic         t;
    logic [W-1:0] expQ;
    logic         expTc;
  } vec_t;

  vec_t vecs[$];
  int   nCompared;
  int   nMismatched;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic addVec(input logic r, input logic tt, input int eq, input logic etc);
    vec_t v;
    v.reset = r;
    v.t     = tt;
    v.expQ  = eq[W-1:0];
    v.expTc = etc;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic tt);
    @(negedge clk);
    reset = r;
    t     = tt;
    #1;
  endtask

  initial begin
    int budget;
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    t           = 1'b0;

    // Reset held, t low
    addVec(1, 0, 0, 0);
    addVec(1, 0, 0, 0);
    // Count up to 7
    for (int i = 1; i <= 7; i++) addVec(0, 1, i, 0);
    // Reset beats t at q=7
    addVec(1, 1, 0, 0);
    // Full wrap: tc only in the q=15 cycle
    for (int i = 1; i <= 15; i++) addVec(0, 1, i, 0);
    addVec(0, 1, 0, 1);
    // Count to 5, hold 4 edges, resume
    for (int i = 1; i <= 5; i++) addVec(0, 1, i, 0);
    for (int i = 0; i < 4; i++) addVec(0, 0, 5, 0);
    addVec(0, 1, 6, 0);
    addVec(0, 1, 7, 0);
    // Reset with t high at q=7, then resume from 0
    addVec(1, 1, 0, 0);
    addVec(0, 1, 1, 0);
    // Count to 3, then alternate t every edge
    addVec(0, 1, 2, 0);
    addVec(0, 1, 3, 0);
    addVec(0, 0, 3, 0);
    addVec(0, 1, 4, 0);
    addVec(0, 0, 4, 0);
    addVec(0, 1, 5, 0);
    addVec(0, 0, 5, 0);
    addVec(0, 1, 6, 0);
    addVec(0, 0, 6, 0);
    addVec(0, 1, 7, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reset, vecs[i].t);
`ifdef ASYNC_FOURBC_TC_EN
      checkOutput($sformatf("tc vec%0d", i), {15'd0, tc}, {15'd0, vecs[i].expTc});
`endif
      @(posedge clk);
      #1;
      checkOutput($sformatf("q vec%0d", i), {12'd0, q}, {12'd0, vecs[i].expQ});
    end

    // Hand sequence: run to terminal count with a bounded wait, then check wrap is clean
    applyStimulus(1'b0, 1'b1);
    budget = 0;
    while (q !== 4'd15 && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("reach 15 within budget", {15'd0, (budget < 20)}, 16'd1);
    checkOutput("steps 7 to 15", budget[15:0], 16'd8);
    @(negedge clk);
`ifdef ASYNC_FOURBC_TC_EN
    checkOutput("tc at 15", {15'd0, tc}, 16'd1);
`endif
    checkOutput("q before wrap", {12'd0, q}, 16'd15);
    @(posedge clk);
    #1;
    checkOutput("wrap q +1ns", {12'd0, q}, 16'd0);
    #4;
    checkOutput("wrap q +5ns", {12'd0, q}, 16'd0);
    #4;
    checkOutput("wrap q +9ns", {12'd0, q}, 16'd0);
`ifdef ASYNC_FOURBC_TC_EN
    checkOutput("tc after wrap", {15'd0, tc}, 16'd0);
`endif

    // Hand sequence: hold with t low across several edges after the wrap
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold after wrap", {12'd0, q}, 16'd0);
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("resume after hold", {12'd0, q}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
